// File: rtl/arb_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_FILL  = 2'd1,
    DC_FILL  = 2'd2,
    DC_WRITE = 2'd3
  } arb_state_t;

  localparam int BLK_WORDS = 8;
  localparam int IDX_W     = 3;
  localparam int MEM_LAT   = 4;
  localparam int OFFSET_W  = 4;

endpackage

// File: rtl/arb_fill_ctr.sv
// Issue/receive word counters for one block fill. The issue side saturates at
// BLK_WORDS; the receive side flags the last word of the block.
module arb_fill_ctr #(
  parameter  int BLK_WORDS = 8,
  localparam int IDX_W     = $clog2(BLK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             iss_en,
  input  logic             rcv_en,
  output logic [IDX_W:0]   iss_cnt,
  output logic [IDX_W-1:0] rcv_cnt,
  output logic             iss_active,
  output logic             rcv_last
);

  assign iss_active = iss_cnt < (IDX_W+1)'(BLK_WORDS);
  assign rcv_last   = rcv_cnt == IDX_W'(BLK_WORDS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else if (clr) begin
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      if (iss_en && iss_active) iss_cnt <= iss_cnt + 1'b1;
      if (rcv_en)               rcv_cnt <= rcv_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates main memory between I-cache fills and D-cache fills/write-throughs.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention (default: D-cache priority).
//
// state    | meaning
// IDLE     | no transfer; samples requests and grants one
// IC_FILL  | pipelined 8-word read for the I-cache
// DC_FILL  | pipelined 8-word read for the D-cache
// DC_WRITE | single-cycle D-cache write-through
module cache_mem_arbiter #(
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 16,
  parameter  int BLK_WORDS = 8,
  localparam int IDX_W     = $clog2(BLK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_fill_we,
  output logic [IDX_W-1:0]  ic_fill_idx,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_fill_we,
  output logic [IDX_W-1:0]  dc_fill_idx,
  output logic              dc_done,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy
);

  import arb_pkg::*;

  // Block offset covers the word index plus the byte bit.
  localparam int OFF_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  arb_state_t state_q, state_d;

  logic              grant_ic, grant_dc, dc_pick;
  logic              fill_st, fill_done;
  logic [ADDR_W-1:0] addr_q, fill_addr, write_addr;
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W:0]    iss_cnt;
  logic [IDX_W-1:0]  rcv_cnt;
  logic              iss_active, rcv_last;

  assign fill_st   = (state_q == IC_FILL) || (state_q == DC_FILL);
  assign fill_done = fill_st && mem_valid && rcv_last;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = I-cache, 1 = D-cache

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_grant <= 1'b0;
    else if (grant_dc || grant_ic)  last_grant <= grant_dc;
  end

  assign dc_pick = dc_req && (!ic_req || !last_grant);
`else
  assign dc_pick = dc_req;
`endif

  arb_fill_ctr #(.BLK_WORDS(BLK_WORDS)) u_fill_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (!fill_st || fill_done),
    .iss_en     (fill_st),
    .rcv_en     (fill_st && mem_valid),
    .iss_cnt    (iss_cnt),
    .rcv_cnt    (rcv_cnt),
    .iss_active (iss_active),
    .rcv_last   (rcv_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_pick) begin
          grant_dc = 1'b1;
          state_d  = dc_wr ? DC_WRITE : DC_FILL;
        end else if (ic_req) begin
          grant_ic = 1'b1;
          state_d  = IC_FILL;
        end
      end
      IC_FILL, DC_FILL: if (fill_done) state_d = IDLE;
      DC_WRITE:         state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Request address/data are captured at grant; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_dc) begin
      addr_q  <= dc_addr;
      wdata_q <= dc_wdata;
    end else if (grant_ic) begin
      addr_q  <= ic_addr;
    end
  end

  assign fill_addr  = (addr_q & BLK_MASK) | (ADDR_W'(iss_cnt[IDX_W-1:0]) << 1);
  assign write_addr = addr_q & ~ADDR_W'(1);

  always_comb begin
    ic_fill_we  = 1'b0;
    ic_fill_idx = '0;
    ic_done     = 1'b0;
    dc_fill_we  = 1'b0;
    dc_fill_idx = '0;
    dc_done     = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      IC_FILL: begin
        mem_en     = iss_active;
        if (iss_active) mem_addr = fill_addr;
        ic_fill_we = mem_valid;
        if (mem_valid) ic_fill_idx = rcv_cnt;
        ic_done    = fill_done;
      end
      DC_FILL: begin
        mem_en     = iss_active;
        if (iss_active) mem_addr = fill_addr;
        dc_fill_we = mem_valid;
        if (mem_valid) dc_fill_idx = rcv_cnt;
        dc_done    = fill_done;
      end
      DC_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = write_addr;
        mem_wdata = wdata_q;
        dc_done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign fill_data = mem_rdata;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
// Honours ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        ic_req, dc_req, dc_wr;
  logic [15:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_fill_we, dc_fill_we, ic_done, dc_done;
  logic [2:0]  ic_fill_idx, dc_fill_idx;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_valid, busy;
  logic        stray;

  int n_pass  = 0;
  int n_total = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_fill_we(ic_fill_we),
    .ic_fill_idx(ic_fill_idx), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_fill_we(dc_fill_we), .dc_fill_idx(dc_fill_idx), .dc_done(dc_done),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA55A;
  endfunction

  // Memory model: reads captured at the clock edge return 4 cycles later.
  logic [3:0]  v_sr;
  logic [15:0] a0, a1, a2, a3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sr <= '0; a0 <= '0; a1 <= '0; a2 <= '0; a3 <= '0;
    end else begin
      v_sr <= {v_sr[2:0], mem_en & ~mem_wr};
      a0 <= mem_addr; a1 <= a0; a2 <= a1; a3 <= a2;
    end
  end
  assign mem_valid = v_sr[3] | stray;
  assign mem_rdata = v_sr[3] ? memf(a3) : (stray ? 16'hDEAD : 16'h0000);

  function automatic logic [63:0] pk(
      input logic busy_i, en_i, wr_i, input logic [15:0] addr_i, wdata_i,
      input logic icwe_i, input logic [2:0] icidx_i, input logic icdone_i,
      input logic dcwe_i, input logic [2:0] dcidx_i, input logic dcdone_i,
      input logic [15:0] fd_i);
    return {3'b000, busy_i, en_i, wr_i, addr_i, wdata_i, icwe_i, icidx_i, icdone_i,
            dcwe_i, dcidx_i, dcdone_i, fd_i};
  endfunction

  // Don't-care fields (address without enable, index without strobe) are masked.
  function automatic logic [63:0] actual();
    return pk(busy, mem_en, mem_wr, mem_en ? mem_addr : 16'h0,
              (mem_en && mem_wr) ? mem_wdata : 16'h0,
              ic_fill_we, ic_fill_we ? ic_fill_idx : 3'd0, ic_done,
              dc_fill_we, dc_fill_we ? dc_fill_idx : 3'd0, dc_done, fill_data);
  endfunction

  // Expected outputs in cycle c of a transaction whose grant cycle is c = 0.
  function automatic logic [63:0] exp_cycle(input int c, input bit is_dc, input bit wr,
                                            input logic [15:0] base, input logic [15:0] wdata);
    logic b, en, mw, we, dn;
    logic [15:0] a, wd, fd;
    logic [2:0] idx;
    b = 0; en = 0; mw = 0; we = 0; dn = 0; a = '0; wd = '0; fd = '0; idx = '0;
    if (wr) begin
      if (c == 1) begin b = 1; en = 1; mw = 1; a = base; wd = wdata; dn = 1; end
    end else begin
      b = (c >= 1) && (c <= 12);
      if (c >= 1 && c <= 8) begin en = 1; a = base + 16'(2 * (c - 1)); end
      if (c >= 5 && c <= 12) begin
        we = 1; idx = 3'(c - 5); fd = memf(base + 16'(2 * (c - 5)));
      end
      dn = (c == 12);
    end
    return is_dc ? pk(b, en, mw, a, wd, 1'b0, 3'd0, 1'b0, we, idx, dn, fd)
                 : pk(b, en, mw, a, wd, we, idx, dn, 1'b0, 3'd0, 1'b0, fd);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drop_all();
    ic_req = 0; dc_req = 0; dc_wr = 0;
  endtask

  task automatic run_txn(input string name, input bit is_dc, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] base);
    int last;
    @(negedge clk);
    if (is_dc) begin dc_req = 1; dc_wr = wr; dc_addr = addr; dc_wdata = wdata; end
    else begin ic_req = 1; ic_addr = addr; end
    last = wr ? 2 : 13;
    for (int c = 0; c <= last; c++) begin
      #1;
      check($sformatf("%s_c%0d", name, c), actual(), exp_cycle(c, is_dc, wr, base, wdata));
      @(negedge clk);
      if (c == 0) begin ic_addr = 16'hFFFF; dc_addr = 16'hFFFF; dc_wdata = 16'h0000; dc_wr = ~wr; end
      if (c == last - 1) drop_all();
    end
  endtask

  task automatic contend(input string name, input bit dc_first);
    int cyc;
    logic [15:0] b1, b2;
    b1 = dc_first ? 16'h0400 : 16'h2000;
    b2 = dc_first ? 16'h2000 : 16'h0400;
    @(negedge clk);
    ic_req = 1; ic_addr = 16'h2006; dc_req = 1; dc_wr = 0; dc_addr = 16'h0400;
    @(negedge clk); #1;
    check({name, "_first_addr"}, 64'({mem_en, mem_addr}), 64'({1'b1, b1}));
    cyc = 1;
    while (!(dc_first ? dc_done : ic_done) && cyc < 40) begin @(negedge clk); #1; cyc++; end
    check({name, "_first_done_cycle"}, 64'(cyc), 64'd12);
    @(negedge clk);
    if (dc_first) dc_req = 0; else ic_req = 0;
    #1; cyc = 0;
    while (!mem_en && cyc < 10) begin @(negedge clk); #1; cyc++; end
    check({name, "_second_gap"}, 64'(cyc), 64'd1);
    check({name, "_second_addr"}, 64'(mem_addr), 64'(b2));
    cyc = 1;
    while (!(dc_first ? ic_done : dc_done) && cyc < 40) begin @(negedge clk); #1; cyc++; end
    check({name, "_second_done_cycle"}, 64'(cyc), 64'd12);
    @(negedge clk);
    drop_all();
  endtask

  typedef struct {
    string       name;
    bit          is_dc;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_base;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] e;
    int cnt;
    vecs[0] = '{"ic_fill_1236",  1'b0, 1'b0, 16'h1236, 16'h0000, 16'h1230};
    vecs[1] = '{"dc_fill_0400",  1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0400};
    vecs[2] = '{"ic_fill_fffe",  1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0};
    vecs[3] = '{"dc_fill_7c9b",  1'b1, 1'b0, 16'h7C9B, 16'h0000, 16'h7C90};
    vecs[4] = '{"dc_write_1235", 1'b1, 1'b1, 16'h1235, 16'h5A5A, 16'h1234};
    vecs[5] = '{"dc_write_00a5", 1'b1, 1'b1, 16'h00A5, 16'hBEEF, 16'h00A4};

    rst = 1; stray = 0; drop_all();
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    @(negedge clk); @(negedge clk); #1;
    check("reset_outputs", actual(), 64'd0);
    @(negedge clk);
    rst = 0;

    contend("contend_after_reset", 1'b1);

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].name, vecs[i].is_dc, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_base);

    // Last grant was a D-cache write.
    contend("contend_after_dcw", !RR);

    // D-cache request arrives mid I-cache fill; stray mem_valid in the IDLE gap.
    @(negedge clk);
    ic_req = 1; ic_addr = 16'h1236;
    for (int c = 0; c <= 26; c++) begin
      #1;
      if (c <= 12) e = exp_cycle(c, 1'b0, 1'b0, 16'h1230, 16'h0);
      else         e = exp_cycle(c - 13, 1'b1, 1'b0, 16'h0400, 16'h0);
      if (c == 13) e[15:0] = 16'hDEAD;
      check($sformatf("mid_fill_c%0d", c), actual(), e);
      @(negedge clk);
      if (c == 4)  begin dc_req = 1; dc_wr = 0; dc_addr = 16'h0400; end
      if (c == 12) begin ic_req = 0; stray = 1; end
      if (c == 13) stray = 0;
      if (c == 25) drop_all();
    end

    // Reset after three returned words of a D-cache fill.
    @(negedge clk);
    dc_req = 1; dc_wr = 0; dc_addr = 16'h0400;
    for (int c = 0; c < 8; c++) @(negedge clk);
    #1;
    check("pre_rst_dc_fill_we", 64'({dc_fill_we, dc_fill_idx}), 64'({1'b1, 3'd3}));
    rst = 1;
    #1;
    check("rst_mid_outputs", actual(), 64'd0);
    drop_all();
    @(negedge clk);
    rst = 0;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); #1;
      if (dc_done || busy) cnt++;
    end
    check("rst_no_done_or_busy", 64'(cnt), 64'd0);
    run_txn("post_rst_ic_fill", 1'b0, 1'b0, 16'h3338, 16'h0000, 16'h3330);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single multi-cycle main memory between the I-cache (fetch-stage miss fills) and the D-cache (MEM-stage miss fills and write-through stores).
- Sequences 8-word block fills as pipelined word reads, steers returned data to the owning cache, and signals completion.
- The pipeline stalls (IF/ID, ID/EX, EX/MEM, MEM/WB write enables) are derived from the outstanding requests and done pulses.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- BLK_WORDS, 8, words per cache block (power of two; index width IDX_W = log2(BLK_WORDS)).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- ic_req  in  1  I-cache miss fill request; held until ic_done
- ic_addr  in  ADDR_W  I-cache miss address; low 4 bits ignored
- ic_fill_we  out  1  write fill_data into I-cache line word ic_fill_idx
- ic_fill_idx  out  IDX_W  word index within block
- ic_done  out  1  one-cycle pulse: I-cache fill complete
- dc_req  in  1  D-cache request; held until dc_done
- dc_wr  in  1  1 = single-word write-through, 0 = block fill
- dc_addr  in  ADDR_W  D-cache address
- dc_wdata  in  DATA_W  store data
- dc_fill_we  out  1  D-cache fill write strobe
- dc_fill_idx  out  IDX_W  word index within block
- dc_done  out  1  one-cycle pulse: D-cache fill or write complete
- fill_data  out  DATA_W  returned word (= mem_rdata), shared by both caches
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  mem_rdata valid (fixed 4-cycle read latency, pipelined)
- busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE; issue counter, receive counter, latched base, and last_grant all 0; every output 0.
- The memory is reset by the same rst, so no stale returns exist after reset.
- FSM states: IDLE, IC_FILL, DC_FILL, DC_WRITE.
- IDLE transitions:
  - dc_req & dc_wr -> DC_WRITE
  - dc_req & !dc_wr -> DC_FILL
  - else ic_req -> IC_FILL
  - else stay IDLE
  - The grant cycle latches the base address, taking addr[15:4].
- Fixed priority: D-cache over I-cache (older instruction).
- IC_FILL / DC_FILL, issue side:
  - iss_cnt runs 0..BLK_WORDS-1.
  - mem_en = 1 and mem_wr = 0 while iss_cnt < BLK_WORDS.
  - mem_addr = {base[15:4], iss_cnt, 1'b0}.
  - iss_cnt increments each cycle and saturates at BLK_WORDS.
  - First issue is in the cycle after the grant.
- IC_FILL / DC_FILL, receive side:
  - On mem_valid: owner's fill_we = 1, fill_idx = rcv_cnt; rcv_cnt increments.
  - The other cache's strobes stay 0.
  - When mem_valid & rcv_cnt == BLK_WORDS-1: owner's done = 1 (combinational, same cycle as the last fill write). Next state IDLE; counters cleared.
  - Nominal fill: 1 grant cycle + 8 issue cycles + 4 drain cycles. The grant edge is edge 0; done is asserted in cycle 12.
- DC_WRITE: mem_en = 1, mem_wr = 1, mem_addr = dc_addr with bit 0 forced to 0, mem_wdata = dc_wdata, dc_done = 1. Exactly one cycle, then IDLE.
- Requester protocol:
  - The requester drops req in the cycle after done.
  - The arbiter's first IDLE cycle after done samples fresh requests, so the same requester cannot be double-served.
- Ignored inputs:
  - mem_valid in IDLE or DC_WRITE is ignored.
  - req changes during a non-owner's service are ignored until IDLE.
  - dc_addr, dc_wr, and ic_addr changes after the grant are ignored.
- fill_data = mem_rdata at all times (zero latency).
- Async reset mid-fill: immediate return to IDLE; done is never asserted for the aborted transfer.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - A last_grant flop (0 = IC, 1 = DC) is updated on every grant.
  - If ic_req and dc_req are both high in IDLE, the requester not granted last wins.
  - Single requests are granted directly.
  - last_grant resets to 0, so the first contention goes to the D-cache.
- Not defined: fixed D-cache priority and no last_grant flop.

Decomposition:
- Shared package arb_pkg:
  - State enum {IDLE, IC_FILL, DC_FILL, DC_WRITE}
  - Constants BLK_WORDS = 8, IDX_W = 3, MEM_LAT = 4, OFFSET_W = 4
- One sub-module, arb_fill_ctr: the issue/receive counter pair with clear, saturate, and last-word flag, instantiated once.

Test Plan:
- ic_req, ic_addr = 0x1236 -> mem_addr 0x1230, 0x1232, …, 0x123E on consecutive cycles. ic_fill_we ×8 with idx 0..7 carrying mem_rdata. ic_done one pulse in cycle 12; dc strobes stay 0.
- ic_req and dc_req(fill, 0x0400) in the same cycle -> DC_FILL first, dc_done, then IC_FILL begins within 2 cycles. With ARB_ROUND_ROBIN_EN and last_grant = DC, IC is served first.
- dc_req, dc_wr = 1, dc_addr = 0x00A5, dc_wdata = 0xBEEF -> one cycle with mem_en = 1, mem_wr = 1, mem_addr = 0x00A4, mem_wdata = 0xBEEF, and dc_done = 1; busy drops the next cycle.
- dc_req asserted during cycle 5 of an IC_FILL -> no D-cache service until ic_done. The D-cache grant occurs in the first IDLE cycle; a stray mem_valid in IDLE produces no fill_we.
- rst asserted after 3 returned words of a DC_FILL -> all outputs 0 immediately, busy = 0, no dc_done. A new ic_req after reset fills cleanly with idx starting at 0.
